munoc_flit_payload_assembler: RTL and testbench

- Downstream of the slave-side FNI flit receive stage.
- Consumes the payload (body) flit stream that stage forwards: one flit per accepted enable, phit-wide data, last flag.
- Packs consecutive flits into one data beat of the configured data width, with a per-phit-lane strobe, and presents it on a valid/ready interface toward the AXI/APB write-data path.
- Decouples the two sides with an assembly register plus a one-entry output register, so assembly continues while the consumer stalls.

---
 rtl/munoc_flit_payload_assembler.sv | 153 +++++++++++++++
 tb/tb_munoc_flit_payload_assembler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/munoc_flit_payload_assembler.sv
// ============================================================================
//  munoc_flit_payload_assembler
//  Packs phit-wide payload flits into data beats with a per-lane strobe.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module munoc_flit_payload_assembler #(
  parameter  int BW_PHIT  = 8,
  parameter  int BW_DATA  = 32,
  localparam int NUM_LANE = BW_DATA / BW_PHIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flit_valid,
  input  logic                flit_last,
  input  logic [BW_PHIT-1:0]  flit_data,
  output logic                flit_ready,
  output logic                beat_valid,
  input  logic                beat_ready,
  output logic [BW_DATA-1:0]  beat_data,
  output logic [NUM_LANE-1:0] beat_strb,
  output logic                beat_last,
  output logic [15:0]         pkt_count
);

  localparam int                 c_IDX_W    = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_LANE - 1);

  localparam logic [0:0] c_ST_FILL = 1'b0;
  localparam logic [0:0] c_ST_PEND = 1'b1;

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic [c_IDX_W-1:0]  r_idx;
  logic [BW_DATA-1:0]  r_acc_data;
  logic [NUM_LANE-1:0] r_acc_strb;
  logic                r_acc_last;
  logic                r_beat_valid;
  logic [BW_DATA-1:0]  r_beat_data;
  logic [NUM_LANE-1:0] r_beat_strb;
  logic                r_beat_last;
  logic [15:0]         r_pkt_count;

  logic                w_accept;
  logic                w_complete;
  logic                w_out_free;
  logic                w_load_new;
  logic                w_load_pend;
  logic [BW_DATA-1:0]  w_new_data;
  logic [NUM_LANE-1:0] w_new_strb;

  assign w_accept    = flit_valid && flit_ready;
  assign w_complete  = w_accept && ((r_idx == c_LAST_IDX) || flit_last);
  assign w_out_free  = !r_beat_valid || beat_ready;
  assign w_load_new  = w_complete && w_out_free;
  assign w_load_pend = (r_state == c_ST_PEND) && beat_ready;

  // Accumulator contents with the incoming flit merged into lane idx; lane 0 is the MSB lane.
  for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
    logic w_hit;
    assign w_hit = w_accept && (r_idx == c_IDX_W'(g));
    assign w_new_data[BW_DATA-1-g*BW_PHIT -: BW_PHIT] =
      w_hit ? flit_data : r_acc_data[BW_DATA-1-g*BW_PHIT -: BW_PHIT];
    assign w_new_strb[NUM_LANE-1-g] = w_hit | r_acc_strb[NUM_LANE-1-g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_FILL: if (w_complete && !w_out_free) w_state_nxt = c_ST_PEND;
      c_ST_PEND: if (beat_ready)                w_state_nxt = c_ST_FILL;
      default:                                  w_state_nxt = c_ST_FILL;
    endcase
  end

  always_comb begin
    flit_ready = (r_state == c_ST_FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= '0;
      r_acc_data   <= '0;
      r_acc_strb   <= '0;
      r_acc_last   <= 1'b0;
      r_beat_valid <= 1'b0;
      r_beat_data  <= '0;
      r_beat_strb  <= '0;
      r_beat_last  <= 1'b0;
      r_pkt_count  <= '0;
    end else begin
      if (r_state == c_ST_PEND) begin
        if (beat_ready) begin
          r_acc_data <= '0;
          r_acc_strb <= '0;
          r_acc_last <= 1'b0;
        end
      end else if (w_complete) begin
        r_idx <= '0;
        if (w_out_free) begin
          r_acc_data <= '0;
          r_acc_strb <= '0;
          r_acc_last <= 1'b0;
        end else begin
          // Output register busy: park the finished beat here until handoff.
          r_acc_data <= w_new_data;
          r_acc_strb <= w_new_strb;
          r_acc_last <= flit_last;
        end
      end else if (w_accept) begin
        r_acc_data <= w_new_data;
        r_acc_strb <= w_new_strb;
        r_idx      <= r_idx + c_IDX_W'(1);
      end

      if (w_load_new) begin
        r_beat_valid <= 1'b1;
        r_beat_data  <= w_new_data;
        r_beat_strb  <= w_new_strb;
        r_beat_last  <= flit_last;
      end else if (w_load_pend) begin
        r_beat_valid <= 1'b1;
        r_beat_data  <= r_acc_data;
        r_beat_strb  <= r_acc_strb;
        r_beat_last  <= r_acc_last;
      end else if (beat_ready) begin
        r_beat_valid <= 1'b0;
      end

      if (r_beat_valid && beat_ready && r_beat_last) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
    end
  end

  assign beat_valid = r_beat_valid;
  assign beat_data  = r_beat_data;
  assign beat_strb  = r_beat_strb;
  assign beat_last  = r_beat_last;
  assign pkt_count  = r_pkt_count;

endmodule

`default_nettype wire

// File: tb/tb_munoc_flit_payload_assembler.sv
// ============================================================================
//  tb_munoc_flit_payload_assembler
//  Directed vector table plus hand-written reset, stream and wrap sequences.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_munoc_flit_payload_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        flit_valid;
  logic        flit_last;
  logic [7:0]  flit_data;
  logic        flit_ready;
  logic        beat_valid;
  logic        beat_ready;
  logic [31:0] beat_data;
  logic [3:0]  beat_strb;
  logic        beat_last;
  logic [15:0] pkt_count;

  munoc_flit_payload_assembler #(.BW_PHIT(8), .BW_DATA(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flit_valid (flit_valid),
    .flit_last  (flit_last),
    .flit_data  (flit_data),
    .flit_ready (flit_ready),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_data  (beat_data),
    .beat_strb  (beat_strb),
    .beat_last  (beat_last),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        l;
    logic [7:0]  d;
    logic        br;
    logic        fr;
    logic        bv;
    logic [31:0] bd;
    logic [3:0]  bs;
    logic        bl;
    logic [15:0] pc;
  } vec_t;

  localparam int c_NVEC = 26;
  vec_t tbl [c_NVEC];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [7:0] d, input logic br);
    flit_valid = v;
    flit_last  = l;
    flit_data  = d;
    beat_ready = br;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".bv"}, 32'(beat_valid), 32'd0);
    chk({tag, ".bd"}, beat_data, 32'd0);
    chk({tag, ".bs"}, 32'(beat_strb), 32'd0);
    chk({tag, ".bl"}, 32'(beat_last), 32'd0);
    chk({tag, ".pc"}, 32'(pkt_count), 32'd0);
  endtask

  logic [31:0] sb_data [8];
  logic        sb_last [8];
  int          sb_cyc  [8];
  int          nb;
  int          bad;

  initial begin
    // Row: inputs applied for the next edge | outputs expected before that edge.
    //            v     l     d      br   | fr    bv    bd            bs     bl    pc
    tbl[0]  = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h11223344, 4'hF, 1'b1, 16'd0};
    tbl[5]  = '{1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd1};
    tbl[6]  = '{1'b1, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd1};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'hAABB0000, 4'hC, 1'b1, 16'd1};
    tbl[8]  = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd2};
    tbl[9]  = '{1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd2};
    tbl[10] = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd2};
    tbl[11] = '{1'b1, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd2};
    tbl[12] = '{1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 1'b1, 32'h01020304, 4'hF, 1'b0, 16'd2};
    tbl[13] = '{1'b1, 1'b0, 8'h06, 1'b0, 1'b1, 1'b1, 32'h01020304, 4'hF, 1'b0, 16'd2};
    tbl[14] = '{1'b1, 1'b0, 8'h07, 1'b0, 1'b1, 1'b1, 32'h01020304, 4'hF, 1'b0, 16'd2};
    tbl[15] = '{1'b1, 1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 32'h01020304, 4'hF, 1'b0, 16'd2};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h01020304, 4'hF, 1'b0, 16'd2};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h01020304, 4'hF, 1'b0, 16'd2};
    tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h05060708, 4'hF, 1'b1, 16'd2};
    tbl[19] = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd3};
    tbl[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd3};
    tbl[21] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd3};
    tbl[22] = '{1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd3};
    tbl[23] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h5A000000, 4'h8, 1'b1, 16'd3};
    tbl[24] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h5A000000, 4'h8, 1'b1, 16'd3};
    tbl[25] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd4};

    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < c_NVEC; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d.fr", i), 32'(flit_ready), 32'(tbl[i].fr));
      chk($sformatf("vec%0d.bv", i), 32'(beat_valid), 32'(tbl[i].bv));
      if (tbl[i].bv) begin
        chk($sformatf("vec%0d.bd", i), beat_data, tbl[i].bd);
        chk($sformatf("vec%0d.bs", i), 32'(beat_strb), 32'(tbl[i].bs));
        chk($sformatf("vec%0d.bl", i), 32'(beat_last), 32'(tbl[i].bl));
      end
      chk($sformatf("vec%0d.pc", i), 32'(pkt_count), 32'(tbl[i].pc));
      drive(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].br);
    end

    // Sustained stream: 16 back-to-back flits, beats expected every 4 cycles.
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c < 16) chk($sformatf("stream.fr%0d", c), 32'(flit_ready), 32'd1);
      if (beat_valid && nb < 8) begin
        sb_data[nb] = beat_data;
        sb_last[nb] = beat_last;
        sb_cyc[nb]  = c;
        nb++;
      end
      if (c < 16) drive(1'b1, c == 15, 8'(8'h10 + c), 1'b1);
      else        drive(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("stream.nbeats", 32'(nb), 32'd4);
    for (int b = 0; b < 4 && b < nb; b++) begin
      logic [31:0] exp_d;
      exp_d = {8'(8'h10 + 4*b), 8'(8'h11 + 4*b), 8'(8'h12 + 4*b), 8'(8'h13 + 4*b)};
      chk($sformatf("stream.bd%0d", b), sb_data[b], exp_d);
      chk($sformatf("stream.bl%0d", b), 32'(sb_last[b]), 32'(b == 3));
      chk($sformatf("stream.cyc%0d", b), 32'(sb_cyc[b]), 32'(4 + 4*b));
    end
    @(negedge clk);
    chk("stream.pc", 32'(pkt_count), 32'd5);

    // Reset with a half-filled accumulator.
    drive(1'b1, 1'b0, 8'hE1, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'hE2, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    #2 rst = 1'b1;
    #1 chk_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid.fr", 32'(flit_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      drive(1'b1, k == 3, 8'(8'hC1 + k), 1'b1);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rst_mid.bv", 32'(beat_valid), 32'd1);
    chk("rst_mid.bd", beat_data, 32'hC1C2C3C4);
    chk("rst_mid.bs", 32'(beat_strb), 32'hF);
    chk("rst_mid.bl", 32'(beat_last), 32'd1);
    @(negedge clk);
    chk("rst_mid.pc", 32'(pkt_count), 32'd1);

    // Reset while a complete beat is parked behind a stalled output.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, k == 7, 8'(k + 1), 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_pend.fr_pre", 32'(flit_ready), 32'd0);
    chk("rst_pend.bv_pre", 32'(beat_valid), 32'd1);
    #2 rst = 1'b1;
    #1 chk_zero("rst_pend");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pend.fr", 32'(flit_ready), 32'd1);
    chk("rst_pend.bv", 32'(beat_valid), 32'd0);

    // Single-flit packets, enough to wrap the packet counter.
    bad = 0;
    for (int i = 0; i <= 65536; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (!(beat_valid === 1'b1 && beat_data === 32'h5A000000 &&
              beat_strb === 4'h8 && beat_last === 1'b1)) bad++;
        if (i == 1) chk("wrap.first_bd", beat_data, 32'h5A000000);
        if (i == 65536) chk("wrap.pc_ffff", 32'(pkt_count), 32'hFFFF);
      end
      if (i < 65536) drive(1'b1, 1'b1, 8'h5A, 1'b1);
      else           drive(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("wrap.bad_beats", 32'(bad), 32'd0);
    @(negedge clk);
    chk("wrap.pc", 32'(pkt_count), 32'd0);
    chk("wrap.bv", 32'(beat_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
